// File: rtl/daten_speicher_steuerung.sv
// rtl/daten_speicher_steuerung.sv - data-side memory controller between CPU data port and synchronous DatenRAM
// Optional range check enabled by macro DATENSTEUERUNG_BEREICH_EN.
module daten_speicher_steuerung #(
   parameter int WORDSIZE     = 32,
   parameter int ADRESSBREITE = 32,
   parameter int WORDS        = 256,
   parameter int LESELATENZ   = 1
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     LeseDaten,
   input  logic                     SchreibeDaten,
   input  logic [ADRESSBREITE-1:0]  DatenAdresse,
   input  logic [WORDSIZE-1:0]      DatenVonCPU,
   output logic [WORDSIZE-1:0]      DatenZurCPU,
   output logic                     DatenGeladen,
   output logic                     DatenGespeichert,
   output logic [$clog2(WORDS)-1:0] RamAdresse,
   output logic [WORDSIZE-1:0]      RamDatenRein,
   output logic                     RamSchreibenAn,
   input  logic [WORDSIZE-1:0]      RamDatenRaus,
   output logic                     AdressFehler
);

   localparam int RAMBREITE = $clog2(WORDS);

   typedef enum logic [2:0] {BEREIT, LESEN, SCHREIBEN, FERTIG, WARTEN} zustand_t;

   zustand_t   zustand;
   logic [2:0] zaehler;
   logic       leseFehler;
   logic       ausserhalb;
   logic       unusedAdressBits;

`ifdef DATENSTEUERUNG_BEREICH_EN
   assign ausserhalb = (DatenAdresse >= ADRESSBREITE'(WORDS));
`else
   assign ausserhalb = 1'b0;
`endif

   // Without the range check the upper address bits are simply discarded (wrap mod WORDS).
   assign unusedAdressBits = ^DatenAdresse[ADRESSBREITE-1:RAMBREITE];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         zustand          <= BEREIT;
         zaehler          <= '0;
         leseFehler       <= 1'b0;
         DatenZurCPU      <= '0;
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;
         RamAdresse       <= '0;
         RamDatenRein     <= '0;
         RamSchreibenAn   <= 1'b0;
         AdressFehler     <= 1'b0;
      end else begin
         DatenGeladen     <= 1'b0;
         DatenGespeichert <= 1'b0;
         RamSchreibenAn   <= 1'b0;
         case (zustand)
            BEREIT: begin
               // Store wins over a simultaneous load request.
               if (SchreibeDaten) begin
                  RamAdresse       <= DatenAdresse[RAMBREITE-1:0];
                  RamDatenRein     <= DatenVonCPU;
                  RamSchreibenAn   <= !ausserhalb;
                  DatenGespeichert <= 1'b1;
                  if (ausserhalb) AdressFehler <= 1'b1;
                  zustand          <= SCHREIBEN;
               end else if (LeseDaten) begin
                  RamAdresse <= DatenAdresse[RAMBREITE-1:0];
                  zaehler    <= 3'(LESELATENZ);
                  leseFehler <= ausserhalb;
                  if (ausserhalb) AdressFehler <= 1'b1;
                  zustand    <= LESEN;
               end
            end
            SCHREIBEN: zustand <= WARTEN;
            LESEN: begin
               if (zaehler == 3'd0) begin
                  DatenZurCPU  <= leseFehler ? '0 : RamDatenRaus;
                  DatenGeladen <= 1'b1;
                  zustand      <= FERTIG;
               end else begin
                  zaehler <= zaehler - 3'd1;
               end
            end
            FERTIG: zustand <= WARTEN;
            // Hold here until the CPU drops both requests so a level never re-triggers.
            WARTEN: begin
               if (!LeseDaten && !SchreibeDaten) zustand <= BEREIT;
            end
            default: zustand <= BEREIT;
         endcase
      end
   end

endmodule

// File: tb/tb_daten_speicher_steuerung.sv
// tb/tb_daten_speicher_steuerung.sv - scoreboard bench for daten_speicher_steuerung with a latency-LAT RAM model
module tb_daten_speicher_steuerung;

   localparam int LAT = 3;

   logic        Clock;
   logic        Reset;
   logic        LeseDaten;
   logic        SchreibeDaten;
   logic [31:0] DatenAdresse;
   logic [31:0] DatenVonCPU;
   logic [31:0] DatenZurCPU;
   logic        DatenGeladen;
   logic        DatenGespeichert;
   logic [7:0]  RamAdresse;
   logic [31:0] RamDatenRein;
   logic        RamSchreibenAn;
   logic [31:0] RamDatenRaus;
   logic        AdressFehler;

   daten_speicher_steuerung #(
      .WORDSIZE(32), .ADRESSBREITE(32), .WORDS(256), .LESELATENZ(LAT)
   ) dut (
      .Clock(Clock), .Reset(Reset), .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
      .DatenAdresse(DatenAdresse), .DatenVonCPU(DatenVonCPU), .DatenZurCPU(DatenZurCPU),
      .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
      .RamAdresse(RamAdresse), .RamDatenRein(RamDatenRein), .RamSchreibenAn(RamSchreibenAn),
      .RamDatenRaus(RamDatenRaus), .AdressFehler(AdressFehler)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   function automatic logic [31:0] initWert(int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // RAM model: synchronous write, read data valid LAT edges after the address.
   logic [31:0] ramMem [256];
   logic [31:0] pipe [LAT];
   always @(posedge Clock) begin
      if (!Reset) begin
         for (int i = 0; i < 256; i++) ramMem[i] <= initWert(i);
      end else if (RamSchreibenAn) begin
         ramMem[RamAdresse] <= RamDatenRein;
      end
      pipe[0] <= ramMem[RamAdresse];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign RamDatenRaus = pipe[LAT-1];

   typedef struct {bit isLoad; logic [31:0] data; int cyc;} erw_t;
   typedef struct {logic [7:0] addr; logic [31:0] data; int cyc;} wr_t;
   erw_t pulseQ[$];
   wr_t  wrQ[$];
   erw_t e;
   wr_t  w;
   logic [31:0] shadow [256];
   logic [31:0] lastLoad = 32'h0;
   logic        expFehler = 1'b0;

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge Clock) begin
      if (Reset) begin
         if (DatenGeladen || DatenGespeichert) begin
            if (pulseQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL puls_unerwartet actual=geladen%0b_gespeichert%0b required=kein_puls cyc=%0d",
                        DatenGeladen, DatenGespeichert, cyc);
            end else begin
               e = pulseQ.pop_front();
               chk("puls_art", {31'b0, DatenGeladen}, {31'b0, e.isLoad});
               chk("puls_zyklus", 32'(cyc), 32'(e.cyc));
               if (e.isLoad) begin
                  chk("ladewert", DatenZurCPU, e.data);
                  lastLoad = e.data;
               end else begin
                  chk("haltewert", DatenZurCPU, lastLoad);
               end
            end
         end
         if (RamSchreibenAn) begin
            if (wrQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL schreiben_unerwartet actual=adr%h required=kein_schreiben cyc=%0d", RamAdresse, cyc);
            end else begin
               w = wrQ.pop_front();
               chk("schreib_adresse", {24'b0, RamAdresse}, {24'b0, w.addr});
               chk("schreib_daten", RamDatenRein, w.data);
               chk("schreib_zyklus", 32'(cyc), 32'(w.cyc));
            end
         end
      end
   end

   // Issue one request at a negedge, hold it 'hold' cycles, then idle until the DUT is ready again.
   task automatic req(bit ld, bit st, logic [31:0] addr, logic [31:0] data, int hold);
      int  acc;
      int  basis;
      int  n;
      bit  inRange;
      erw_t pe;
      wr_t  pw;
`ifdef DATENSTEUERUNG_BEREICH_EN
      inRange = (addr < 32'd256);
`else
      inRange = 1'b1;
`endif
      LeseDaten     = ld;
      SchreibeDaten = st;
      DatenAdresse  = addr;
      DatenVonCPU   = data;
      acc = cyc + 1;
      if (!inRange) expFehler = 1'b1;
      if (st) begin
         pe.isLoad = 1'b0; pe.data = 32'h0; pe.cyc = acc;
         pulseQ.push_back(pe);
         if (inRange) begin
            pw.addr = addr[7:0]; pw.data = data; pw.cyc = acc;
            wrQ.push_back(pw);
            shadow[addr[7:0]] = data;
         end
         basis = 2;
      end else begin
         pe.isLoad = 1'b1; pe.data = inRange ? shadow[addr[7:0]] : 32'h0; pe.cyc = acc + 1 + LAT;
         pulseQ.push_back(pe);
         basis = LAT + 3;
      end
      n = (hold > basis) ? hold : basis;
      repeat (hold) @(negedge Clock);
      LeseDaten     = 1'b0;
      SchreibeDaten = 1'b0;
      repeat (n + 1 - hold) @(negedge Clock);
   endtask

   initial begin
      Reset = 1'b0; LeseDaten = 1'b0; SchreibeDaten = 1'b0;
      DatenAdresse = 32'h0; DatenVonCPU = 32'h0;
      for (int i = 0; i < 256; i++) shadow[i] = initWert(i);
      repeat (3) @(negedge Clock);
      chk("reset_zurcpu", DatenZurCPU, 32'h0);
      chk("reset_pulse", {30'b0, DatenGeladen, DatenGespeichert}, 32'h0);
      chk("reset_ram", {23'b0, RamSchreibenAn, RamAdresse}, 32'h0);
      chk("reset_fehler", {31'b0, AdressFehler}, 32'h0);
      Reset = 1'b1;
      @(negedge Clock);

      // Abort a load in flight; no pulse may follow.
      LeseDaten = 1'b1; DatenAdresse = 32'd9;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      #1;
      chk("abbruch_adresse", {24'b0, RamAdresse}, 32'h0);
      chk("abbruch_zurcpu", DatenZurCPU, 32'h0);
      chk("abbruch_ausgaenge", {28'b0, DatenGeladen, DatenGespeichert, RamSchreibenAn, AdressFehler}, 32'h0);
      chk("abbruch_reindaten", RamDatenRein, 32'h0);
      LeseDaten = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      repeat (LAT + 4) @(negedge Clock);

      req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 2);
      chk("ram5", ramMem[5], 32'hDEADBEEF);
      req(1'b1, 1'b0, 32'd5, 32'h0, LAT + 3);

      req(1'b1, 1'b1, 32'd7, 32'h1, 2);
      chk("ram7", ramMem[7], 32'h1);

      req(1'b1, 1'b0, 32'd7, 32'h0, 20);
      req(1'b1, 1'b0, 32'd7, 32'h0, 1);

      req(1'b0, 1'b1, 32'd259, 32'h12345678, 2);
`ifdef DATENSTEUERUNG_BEREICH_EN
      chk("ram3_unveraendert", ramMem[3], initWert(3));
`else
      chk("ram3_umlauf", ramMem[3], 32'h12345678);
`endif
      chk("adressfehler", {31'b0, AdressFehler}, {31'b0, expFehler});
      req(1'b1, 1'b0, 32'd3, 32'h0, 1);
      req(1'b1, 1'b0, 32'd259, 32'h0, 1);

      for (int a = 0; a < 10; a++) req(1'b1, 1'b0, 32'(a), 32'h0, 1);
      req(1'b0, 1'b1, 32'd0, 32'hA5A5_0F0F, 1);
      for (int a = 0; a < 3; a++) req(1'b1, 1'b0, 32'(a), 32'h0, LAT + 3);

      repeat (10) @(negedge Clock);
      chk("offene_pulse", 32'(pulseQ.size()), 32'h0);
      chk("offene_schreibzugriffe", 32'(wrQ.size()), 32'h0);
      chk("adressfehler_ende", {31'b0, AdressFehler}, {31'b0, expFehler});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
